audio_sample_proc: RTL and testbench
====================================

Name: audio_sample_proc

Overview:
- Parametrised successor to the per-channel FIR and output-select path in the audio top level.
- Accepts one multi-channel codec sample per handshake and optionally adds LFSR noise.
- Optionally applies a 2^LOG2_TAPS-tap moving-average filter.
- Shares one accumulate datapath across channels via a small FSM. Sits between audio_codec readdata and writedata.

Parameters:
- WIDTH, 24, signed sample width per channel
- CHANNELS, 2, channel count (1..8); channel c occupies bits [c*WIDTH +: WIDTH]
- LOG2_TAPS, 3, filter length TAPS = 2^LOG2_TAPS (1..6)
- NOISE_BITS, 8, width of the signed noise term, sign-extended to WIDTH
- LFSR_SEED, 16'hACE1, reset value of the 16-bit noise LFSR; must be nonzero

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous reset, active low
- mode  in  2  0 bypass, 1 noisy, 2 filtered noisy, 3 filtered clean
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept a sample
- in_data  in  CHANNELS*WIDTH  input samples, signed
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts the output
- out_data  out  CHANNELS*WIDTH  processed samples, signed
- sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, in_ready=1, out_valid=0, out_data=0, LFSR=LFSR_SEED, all running sums=0, fill_cnt=0, write pointer=0, mode_q=0, sat_flag=0.
- FSM states:
  - IDLE: in_ready=1. When in_valid, latch in_data and mode into mode_q, advance the LFSR one step (taps 16,14,13,11), then go to PROC with ch=0.
  - PROC: one channel per cycle, ch 0..CHANNELS-1. When ch=CHANNELS-1, go to OUT. in_ready=0.
  - OUT: out_valid=1 and out_data held stable. On out_ready, go to IDLE.
- Latency: CHANNELS+1 cycles from the accept edge to out_valid=1. Throughput: one sample per CHANNELS+2 cycles when out_ready is held high.
- No combinational path from in_valid or out_ready to any output.
- Noise term: sign-extended LFSR[NOISE_BITS-1:0]. The same value applies to every channel of a sample.
- Noisy sample: noisy = x + noise, computed in WIDTH+1 bits and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Filter input per mode: mode 2 uses the noisy sample; mode 3 uses x.
- Filter history: one ring buffer of TAPS entries per channel, in register or RAM.
- Filter step per channel:
  - old = ring[ch][wptr] if fill_cnt==TAPS, else 0.
  - sum[ch] += f_in - old.
  - ring[ch][wptr] = f_in.
  - Result = sum[ch] >>> LOG2_TAPS (arithmetic shift, truncate toward minus infinity).
  - Sum width is WIDTH+LOG2_TAPS, which cannot overflow.
- wptr wraps modulo TAPS and advances once per sample, after the last channel. fill_cnt saturates at TAPS.
- Output per mode: 0 gives x; 1 gives noisy; 2 and 3 give the filter result.
- History is updated only in modes 2 and 3. In modes 0 and 1 the sums and ring are untouched.
- Mode change: if the latched mode differs from the previous mode_q and the new mode is 2 or 3, clear all sums and set fill_cnt=0 before processing. Ring contents need not be cleared.
- Simultaneous OUT with out_ready and in_valid: the sample is not accepted that cycle; it is accepted in the next IDLE cycle.
- Reset mid-PROC or mid-OUT: aborts immediately, out_valid drops, and the partial sample is discarded.

Optional Feature:
- Macro: AUDIO_SAT_FLAG_EN.
- Defined: sat_flag goes high on any noisy-sample saturation in a mode other than 0 and stays high until reset.
- Undefined: no saturation detect logic; sat_flag is tied to 0.

Test Plan:
- Reset, mode=0, CHANNELS=2, in_data={24'h000123, 24'hFFFF00}, out_ready=1 -> out_valid after 3 cycles with out_data identical; in_ready low for cycles 1..3; next accept possible on cycle 4.
- Mode=3, TAPS=8, feed constant 800 on both channels for 10 samples -> outputs 100,200,...,700,800,800,800.
- Mode=1 with first LFSR step from seed 16'hACE1 -> out = x + sext(LFSR[7:0]) with the value checked against a reference model. Then x = 24'h7FFFFF -> out = 24'h7FFFFF when the noise is positive, and sat_flag=1 with AUDIO_SAT_FLAG_EN.
- Mode=3 for 8 samples, then switch to mode 2 -> sums restart from zero; the first mode-2 output is f_in>>>3.
- Hold out_ready=0 for 5 cycles in OUT -> out_data stable, in_ready=0, no second sample accepted; release -> exactly one transfer.
- Assert reset_n=0 during PROC at ch=1 -> out_valid=0 and in_ready=1 after release; the next sample in mode 3 yields f_in>>>3.

Source files
------------

// File: rtl/audio_sample_proc.sv
// audio_sample_proc: multi-channel codec sample processor.
// Per accepted sample: optional LFSR noise, optional 2^LOG2_TAPS-tap moving
// average, one channel per cycle through a shared accumulate datapath.
// Build option: define AUDIO_SAT_FLAG_EN to enable sticky saturation detect
// on sat_flag; when undefined sat_flag is tied low.
module audio_sample_proc #(
    parameter int          WIDTH      = 24,
    parameter int          CHANNELS   = 2,
    parameter int          LOG2_TAPS  = 3,
    parameter int          NOISE_BITS = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      sat_flag
);

    localparam int TAPS   = 1 << LOG2_TAPS;
    localparam int SUM_W  = WIDTH + LOG2_TAPS;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FILL_W = LOG2_TAPS + 1;

    localparam logic [CH_W-1:0]         CH_LAST   = CH_W'(CHANNELS - 1);
    localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(TAPS);
    localparam logic signed [WIDTH-1:0] S_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Clamp a WIDTH+1 bit sum back into the signed WIDTH-bit range.
    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1]) begin
            sat_w = s[WIDTH] ? S_MIN : S_MAX;
        end else begin
            sat_w = s[WIDTH-1:0];
        end
    endfunction

    state_t state_q, state_d;

    logic [CHANNELS*WIDTH-1:0] x_q, x_d;
    logic [CHANNELS*WIDTH-1:0] out_q, out_d;
    logic [1:0]                mode_q, mode_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [LOG2_TAPS-1:0]      wptr_q, wptr_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic signed [SUM_W-1:0]   sum_q [CHANNELS];
    logic signed [SUM_W-1:0]   sum_d [CHANNELS];
    logic signed [WIDTH-1:0]   ring_q [CHANNELS][TAPS];
    logic                      ring_we;

    logic                      accept;
    logic signed [NOISE_BITS-1:0] noise_raw;
    logic signed [WIDTH-1:0]   noise;
    logic signed [WIDTH-1:0]   x_cur;
    logic signed [WIDTH:0]     noisy_wide;
    logic signed [WIDTH-1:0]   noisy_cur;
    logic signed [WIDTH-1:0]   f_in;
    logic signed [WIDTH-1:0]   old_cur;
    logic signed [SUM_W-1:0]   sum_new;
    logic signed [WIDTH-1:0]   filt_cur;
    logic signed [WIDTH-1:0]   res_cur;

    assign accept = (state_q == S_IDLE) && in_valid;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; handshake outputs depend only on the registered state
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_PROC;
            end
            S_PROC: begin
                if (ch_q == CH_LAST) state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shared per-channel datapath for the channel selected by ch_q
    always_comb begin
        noise_raw  = lfsr_q[NOISE_BITS-1:0];
        noise      = WIDTH'(noise_raw);
        x_cur      = x_q[ch_q*WIDTH +: WIDTH];
        noisy_wide = (WIDTH+1)'(x_cur) + (WIDTH+1)'(noise);
        noisy_cur  = sat_w(noisy_wide);
        f_in       = (mode_q == 2'd3) ? x_cur : noisy_cur;
        old_cur    = (fill_q == FILL_FULL) ? ring_q[ch_q][wptr_q] : '0;
        sum_new    = sum_q[ch_q] + SUM_W'(f_in) - SUM_W'(old_cur);
        filt_cur   = WIDTH'(sum_new >>> LOG2_TAPS);
        unique case (mode_q)
            2'd0:    res_cur = x_cur;
            2'd1:    res_cur = noisy_cur;
            default: res_cur = filt_cur;
        endcase
    end

    // Next-state for sample capture, filter history control and output
    always_comb begin
        x_d     = x_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        ch_d    = ch_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        out_d   = out_q;
        sum_d   = sum_q;
        ring_we = 1'b0;

        if (accept) begin
            x_d    = in_data;
            mode_d = mode;
            lfsr_d = lfsr_next(lfsr_q);
            ch_d   = '0;
            // Entering a filtered mode from a different mode restarts the average.
            if ((mode != mode_q) && mode[1]) begin
                for (int c = 0; c < CHANNELS; c++) sum_d[c] = '0;
                fill_d = '0;
            end
        end

        if (state_q == S_PROC) begin
            out_d[ch_q*WIDTH +: WIDTH] = res_cur;
            if (mode_q[1]) begin
                sum_d[ch_q] = sum_new;
                ring_we     = 1'b1;
            end
            if (ch_q == CH_LAST) begin
                ch_d = '0;
                if (mode_q[1]) begin
                    wptr_d = wptr_q + 1'b1;
                    if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    // Control, running sums and output register (cleared by reset)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 2'd0;
            lfsr_q <= LFSR_SEED;
            ch_q   <= '0;
            wptr_q <= '0;
            fill_q <= '0;
            out_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
        end else begin
            mode_q <= mode_d;
            lfsr_q <= lfsr_d;
            ch_q   <= ch_d;
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            sum_q  <= sum_d;
        end
    end

    // Captured sample and history ring; contents are don't-care after reset
    always_ff @(posedge clk) begin
        x_q <= x_d;
        if (ring_we) ring_q[ch_q][wptr_q] <= f_in;
    end

    assign out_data = out_q;

`ifdef AUDIO_SAT_FLAG_EN
    logic sat_q, sat_d;

    // Sticky flag: any clamped noisy add outside bypass mode
    always_comb begin
        sat_d = sat_q;
        if ((state_q == S_PROC) && (mode_q != 2'd0) &&
            (noisy_wide[WIDTH] != noisy_wide[WIDTH-1])) begin
            sat_d = 1'b1;
        end
    end

    // Saturation flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_proc.sv
// Testbench for audio_sample_proc: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_audio_sample_proc;

    localparam int W  = 24;
    localparam int CH = 2;
    localparam int DW = W * CH;
    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;
`ifdef AUDIO_SAT_FLAG_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          sat_flag;

    audio_sample_proc #(
        .WIDTH(W), .CHANNELS(CH), .LOG2_TAPS(3), .NOISE_BITS(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    typedef struct { longint v0; longint v1; } hist_t;
    int unsigned m_lfsr;
    logic [1:0]  m_prev;
    bit          m_sat;
    hist_t       m_hist[$];

    typedef struct {
        logic [1:0]   m;
        logic [W-1:0] x0, x1, e0, e1;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 32'hACE1;
        m_prev = 2'd0;
        m_sat  = 1'b0;
        m_hist.delete();
    endtask

    // Expected output of one sample: history kept as the list of recent
    // filter inputs, averaged with floor division by 8.
    task automatic model_txn(input logic [1:0] m, input logic [DW-1:0] d, output logic [DW-1:0] e);
        int unsigned fb;
        logic [7:0]  nb;
        longint      noise, x, nz, s;
        longint      fin [2];
        longint      r [2];
        hist_t       h;
        fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = ((m_lfsr >> 1) | (fb << 15)) & 32'hFFFF;
        nb     = m_lfsr[7:0];
        noise  = longint'($signed(nb));
        if (m >= 2 && m != m_prev) m_hist.delete();
        m_prev = m;
        for (int c = 0; c < CH; c++) begin
            x  = longint'($signed(d[c*W +: W]));
            nz = x + noise;
            if (nz > MAXV) begin nz = MAXV; if (m != 0) m_sat = 1'b1; end
            if (nz < MINV) begin nz = MINV; if (m != 0) m_sat = 1'b1; end
            fin[c] = (m == 3) ? x : nz;
            r[c]   = (m == 0) ? x : nz;
        end
        if (m >= 2) begin
            h.v0 = fin[0];
            h.v1 = fin[1];
            m_hist.push_back(h);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            for (int c = 0; c < CH; c++) begin
                s = 0;
                for (int i = 0; i < m_hist.size(); i++) s += (c == 0) ? m_hist[i].v0 : m_hist[i].v1;
                r[c] = s >>> 3;
            end
        end
        for (int c = 0; c < CH; c++) e[c*W +: W] = r[c][W-1:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One full transaction; out_ready raised after rdy_delay cycles in OUT.
    task automatic run_txn(input logic [1:0] m, input logic [DW-1:0] d, input int rdy_delay,
                           output logic [DW-1:0] got);
        int n;
        @(negedge clk);
        mode = m; in_data = d; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin total++; bad++; $display("FAIL accept_timeout: in_ready=0 required=1"); end
        @(negedge clk);
        in_valid = 1'b0;
        mode     = 2'($urandom_range(0, 3));
        in_data  = {W'($urandom), W'($urandom)};
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        if (!out_valid) begin total++; bad++; $display("FAIL out_timeout: out_valid=0 required=1"); end
        got = out_data;
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            check("hold_stable", 64'(out_data), 64'(got));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] got, exp, keep;
        logic [1:0]    cm;
        logic [W-1:0]  v [2];
        int            xfer;

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_idle_ready", 64'(in_ready), 64'd1);

        // ---- latency / throughput in bypass mode
        out_ready = 1'b1;
        mode = 2'd0; in_data = {24'hFFFF00, 24'h000123}; in_valid = 1'b1;
        @(negedge clk);                       // accept edge passed: cycle 1
        in_valid = 1'b0;
        check("lat_c1_ready", 64'(in_ready), 64'd0);
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);                       // cycle 2
        check("lat_c2_ready", 64'(in_ready), 64'd0);
        check("lat_c2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);                       // cycle 3
        check("lat_c3_ready", 64'(in_ready), 64'd0);
        check("lat_c3_valid", 64'(out_valid), 64'd1);
        check("lat_c3_data", 64'(out_data), 64'(48'hFFFF00_000123));
        model_txn(2'd0, {24'hFFFF00, 24'h000123}, exp);
        @(negedge clk);                       // cycle 4
        check("lat_c4_ready", 64'(in_ready), 64'd1);
        check("lat_c4_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // ---- mode 1 noise from the first LFSR step (0xACE1 -> 0x5670, noise +0x70)
        do_reset();
        run_txn(2'd1, {24'hFFFFCE, 24'h000064}, 0, got);
        model_txn(2'd1, {24'hFFFFCE, 24'h000064}, exp);
        check("noisy_first_const", 64'(got), 64'(48'h00003E_0000D4));
        check("noisy_first_model", 64'(got), 64'(exp));
        check("noisy_first_sat", 64'(sat_flag), 64'd0);
        run_txn(2'd1, {24'h7FFFFF, 24'h7FFFFF}, 0, got);
        model_txn(2'd1, {24'h7FFFFF, 24'h7FFFFF}, exp);
        check("noisy_clamp_const", 64'(got), 64'(48'h7FFFFF_7FFFFF));
        check("noisy_clamp_model", 64'(got), 64'(exp));
        @(negedge clk);
        check("noisy_clamp_sat", 64'(sat_flag), 64'(SAT_EN));

        // ---- directed table
        do_reset();
        tbl.push_back('{2'd0, 24'h000123, 24'hFFFF00, 24'h000123, 24'hFFFF00});
        for (int k = 1; k <= 10; k++)
            tbl.push_back('{2'd3, 24'd800, 24'd800, W'(((k < 8) ? k : 8) * 100), W'(((k < 8) ? k : 8) * 100)});
        tbl.push_back('{2'd0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000});
        tbl.push_back('{2'd3, 24'hFFFFF8, 24'h000010, 24'hFFFFFF, 24'h000002});
        tbl.push_back('{2'd3, 24'hFFFFFF, 24'h000001, 24'hFFFFFE, 24'h000002});
        for (int i = 0; i < tbl.size(); i++) begin
            run_txn(tbl[i].m, {tbl[i].x1, tbl[i].x0}, i % 3, got);
            model_txn(tbl[i].m, {tbl[i].x1, tbl[i].x0}, exp);
            check($sformatf("tbl[%0d]", i), 64'(got), 64'({tbl[i].e1, tbl[i].e0}));
        end
        check("tbl_sat", 64'(sat_flag), 64'd0);

        // ---- eight filtered-clean samples, then switch to filtered-noisy
        for (int k = 0; k < 8; k++) begin
            v[0] = W'($urandom_range(0, 20000));
            v[1] = W'($urandom_range(0, 20000));
            run_txn(2'd3, {v[1], v[0]}, 0, got);
            model_txn(2'd3, {v[1], v[0]}, exp);
            check("m3_run", 64'(got), 64'(exp));
        end
        run_txn(2'd2, {24'hFFFC18, 24'h0003E8}, 0, got);
        model_txn(2'd2, {24'hFFFC18, 24'h0003E8}, exp);
        check("mode2_first", 64'(got), 64'(exp));

        // ---- backpressure: OUT held 5 cycles with a competing input offered
        @(negedge clk);
        mode = 2'd0; in_data = {24'd222, 24'd111}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        keep = out_data;
        model_txn(2'd0, {24'd222, 24'd111}, exp);
        check("bp_data", 64'(keep), 64'(exp));
        check("bp_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1; in_data = {24'd5, 24'd6}; mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", 64'(out_data), 64'(keep));
            check("bp_hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        xfer = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) xfer++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("bp_one_transfer", 64'(xfer), 64'd1);
        check("bp_idle_after", 64'(in_ready), 64'd1);

        // ---- reset asserted while processing channel 1
        @(negedge clk);
        mode = 2'd3; in_data = {24'd7, 24'd9}; in_valid = 1'b1;
        @(negedge clk);                       // channel 0
        in_valid = 1'b0;
        @(negedge clk);                       // channel 1
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_valid_after", 64'(out_valid), 64'd0);
        check("midrst_ready_after", 64'(in_ready), 64'd1);
        run_txn(2'd3, {24'hFFFFE8, 24'd40}, 0, got);
        model_txn(2'd3, {24'hFFFFE8, 24'd40}, exp);
        check("midrst_first", 64'(got), 64'(48'hFFFFFD_000005));
        check("midrst_model", 64'(got), 64'(exp));

        // ---- randomized traffic
        cm = 2'd3;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) cm = 2'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++) begin
                case ($urandom_range(0, 5))
                    0:       v[c] = 24'h7FFFFF - W'($urandom_range(0, 50));
                    1:       v[c] = 24'h800000 + W'($urandom_range(0, 50));
                    default: v[c] = W'($urandom);
                endcase
            end
            run_txn(cm, {v[1], v[0]}, $urandom_range(0, 3), got);
            model_txn(cm, {v[1], v[0]}, exp);
            check($sformatf("rand[%0d] m%0d", t, cm), 64'(got), 64'(exp));
            @(negedge clk);
            check("rand_sat", 64'(sat_flag), 64'(SAT_EN & m_sat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout: sim time exceeded, required completion");
        $fatal(1);
    end

endmodule
